fpga_cfg_loader: RTL and testbench

//  Upstream configuration stage for the 3x3 fabric top. Accepts a byte-wide bitstream over a

---
 rtl/fpga_cfg_loader.sv | 218 +++++++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader
//   Configuration front end for the 3x3 fabric. A byte-wide bitstream arrives
//   over a valid/ready handshake. It is shifted into a shadow register and then
//   committed in one step to the parallel config vectors. The fabric therefore
//   never sees a partially written configuration.
//
//   Build option: define CFG_CRC_EN to add a CRC-8 trailer check. The CRC uses
//   polynomial 0x07, init 0x00 and processes each byte MSB first. In that build
//   a bad trailer rejects the load and the previous config is kept.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset       in   1       asynchronous, active-low; clears all state
//   cfg_start   in   1       pulse: begin a new load (ignored while busy)
//   in_data     in   8       bitstream byte
//   in_valid    in   1       in_data valid
//   in_ready    out  1       loader accepts a byte this cycle
//   sramConfig  out  SRAM_W  committed LUT config
//   cbconfig    out  CB_W    committed connection-block config
//   sconfig     out  SB_W    committed switch-box config
//   sel         out  SEL_W   committed LB output-register select
//   cfg_busy    out  1       load in progress
//   cfg_done    out  1       level: last load committed
//   cfg_error   out  1       level: last load rejected (always 0 without CFG_CRC_EN)
module fpga_cfg_loader #(
  parameter int SRAM_W = 144,
  parameter int CB_W   = 420,
  parameter int SB_W   = 240,
  parameter int SEL_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SRAM_W-1:0] sramConfig,
  output logic [CB_W-1:0]   cbconfig,
  output logic [SB_W-1:0]   sconfig,
  output logic [SEL_W-1:0]  sel,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error
);

  localparam int TOT_W  = SRAM_W + CB_W + SB_W + SEL_W;
  localparam int NBYTES = (TOT_W + 7) / 8;
  localparam int SH_W   = NBYTES * 8;
  // Trailing pad bits in the last byte. These must be fewer than 8.
  localparam int PAD_W  = SH_W - TOT_W;
  localparam logic [6:0] NBYTES_C = 7'(NBYTES);

  // Without the CRC check, the final byte is committed straight from in_data.
  // In that build the shadow only needs to hold the first NBYTES-1 bytes.
  // With the check, the whole stream must be stored until the trailer arrives.
`ifdef CFG_CRC_EN
  localparam int SHREG_W = SH_W;
`else
  localparam int SHREG_W = SH_W - 8;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_DONE
`ifdef CFG_CRC_EN
    ,
    S_CRC,
    S_ERR
`endif
  } state_t;

  state_t              state_reg, state_next;
  logic [6:0]          cnt_reg;
  logic [SHREG_W-1:0]  shreg_reg;
  logic [TOT_W-1:0]    cfg_reg;
  logic                done_reg;
  logic [TOT_W-1:0]    commit_vec;
  logic                cnt_last;
  logic                start_accept;
  logic                commit_now;
  logic                shift_en;

  assign cnt_last = (cnt_reg == NBYTES_C - 7'd1);
  assign shift_en = (state_reg == S_LOAD) && in_valid;

`ifdef CFG_CRC_EN
  logic       reject_now;
  logic       err_reg;
  logic [7:0] crc_reg;
  logic [7:0] crc_chain [0:8];

  // Bit-serial CRC-8 (poly x^8+x^2+x+1), unrolled over one byte, MSB first.
  assign crc_chain[0] = crc_reg;
  for (genvar gi = 0; gi < 8; gi++) begin : g_crc
    logic fb;
    assign fb = crc_chain[gi][7] ^ in_data[7-gi];
    assign crc_chain[gi+1] = {crc_chain[gi][6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  end

  // The trailer is not shifted in, so the data sits in the whole shadow.
  assign commit_vec = shreg_reg[SH_W-1:PAD_W];
  assign cfg_error  = err_reg;
`else
  // The final byte is taken directly from the bus. This lets the outputs
  // update in the cycle right after it is accepted.
  assign commit_vec = {shreg_reg, in_data[7:PAD_W]};
  assign cfg_error  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and handshake/status outputs
  always_comb begin
    state_next   = state_reg;
    in_ready     = 1'b0;
    cfg_busy     = 1'b0;
    start_accept = 1'b0;
    commit_now   = 1'b0;
`ifdef CFG_CRC_EN
    reject_now   = 1'b0;
`endif
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          start_accept = 1'b1;
          state_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        cfg_busy = 1'b1;
        if (in_valid && cnt_last) begin
`ifdef CFG_CRC_EN
          state_next = S_CRC;
`else
          commit_now = 1'b1;
          state_next = S_COMMIT;
`endif
        end
      end
`ifdef CFG_CRC_EN
      S_CRC: begin
        in_ready = 1'b1;
        cfg_busy = 1'b1;
        if (in_valid) begin
          if (in_data == crc_reg) begin
            commit_now = 1'b1;
            state_next = S_COMMIT;
          end else begin
            reject_now = 1'b1;
            state_next = S_ERR;
          end
        end
      end
      S_ERR: begin
        if (cfg_start) begin
          start_accept = 1'b1;
          state_next   = S_LOAD;
        end
      end
`endif
      // The config registers are already loaded at this point. This state
      // only holds cfg_busy for one cycle while the commit settles.
      S_COMMIT: begin
        cfg_busy   = 1'b1;
        state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: byte counter, shadow, committed config, status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      shreg_reg <= '0;
      cfg_reg   <= '0;
      done_reg  <= 1'b0;
`ifdef CFG_CRC_EN
      crc_reg   <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      if (start_accept) begin
        cnt_reg  <= '0;
        done_reg <= 1'b0;
`ifdef CFG_CRC_EN
        crc_reg  <= '0;
        err_reg  <= 1'b0;
`endif
      end
      if (shift_en) begin
        shreg_reg <= {shreg_reg[SHREG_W-9:0], in_data};
        if (cnt_reg != NBYTES_C) cnt_reg <= cnt_reg + 7'd1;
`ifdef CFG_CRC_EN
        crc_reg <= crc_chain[8];
`endif
      end
      if (commit_now) begin
        cfg_reg  <= commit_vec;
        done_reg <= 1'b1;
      end
`ifdef CFG_CRC_EN
      if (reject_now) err_reg <= 1'b1;
`endif
    end
  end

  assign {sramConfig, cbconfig, sconfig, sel} = cfg_reg;
  assign cfg_done = done_reg;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
module tb_fpga_cfg_loader;
  localparam int SRAM_W = 144;
  localparam int CB_W   = 420;
  localparam int SB_W   = 240;
  localparam int SEL_W  = 9;
  localparam int TOT_W  = SRAM_W + CB_W + SB_W + SEL_W;
  localparam int NB     = (TOT_W + 7) / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SRAM_W-1:0] sramConfig;
  logic [CB_W-1:0]   cbconfig;
  logic [SB_W-1:0]   sconfig;
  logic [SEL_W-1:0]  sel;
  logic              cfg_busy, cfg_done, cfg_error;

  fpga_cfg_loader dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .sramConfig(sramConfig),
    .cbconfig(cbconfig), .sconfig(sconfig), .sel(sel), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [TOT_W-1:0] vec;
    int               acc_cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] load_bytes [NB];
  int         last_acc_cyc;
  int         first_acc_cyc;

  task automatic check(input string name, input logic [TOT_W-1:0] act,
                       input logic [TOT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: concatenate the bytes first-to-last into one long word
  // and keep the top TOT_W bits.
  function automatic logic [TOT_W-1:0] model_vec();
    logic [NB*8-1:0] flat;
    flat = '0;
    for (int k = 0; k < NB; k++) flat[NB*8-1-8*k -: 8] = load_bytes[k];
    return flat[NB*8-1 -: TOT_W];
  endfunction

  // Monitor: check each commit against the scoreboard. Between commits, check
  // that the outputs do not move.
  initial begin
    logic [TOT_W-1:0] prev_cfg, cur;
    logic prev_done;
    exp_t e;
    prev_cfg = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_cfg = '0;
        prev_done = 1'b0;
      end else begin
        cur = {sramConfig, cbconfig, sconfig, sel};
        if (cfg_done && !prev_done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_commit", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("commit_data", cur, e.vec);
            check("commit_latency", cyc, e.acc_cyc);
            check("ready_low_after_last", in_ready, 0);
            check("error_low", cfg_error, 0);
          end
        end else begin
          check("cfg_stable", cur, prev_cfg);
        end
        prev_cfg = cur;
        prev_done = cfg_done;
      end
    end
  end

  // Present one byte until it is accepted. Optionally pulse cfg_start in the
  // first cycle.
  task automatic send_byte(input logic [7:0] b, input bit start_pulse);
    bit ok, rdy;
    ok = 0;
    in_data = b;
    in_valid = 1'b1;
    cfg_start = start_pulse;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
    last_acc_cyc = cyc;
    check("ready_timeout", ok, 1);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_data = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    @(negedge clk);
    check("start_clears_done", cfg_done, 0);
    check("busy_in_load", cfg_busy, 1);
    @(posedge clk);
    #1;
  endtask

  // mode 0: all 0xFF back-to-back; 1: value i with 50% valid;
  // 2: random with random gaps; 3: random with a cfg_start pulse at byte 50.
  // When nbytes < NB, the load is abandoned before it completes.
  task automatic do_load(input int mode, input int nbytes);
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      case (mode)
        0: load_bytes[i] = 8'hFF;
        1: load_bytes[i] = 8'(i);
        default: load_bytes[i] = 8'($urandom);
      endcase
    end
    start_load();
    for (int i = 0; i < nbytes; i++) begin
      if (mode == 1 && i > 0) idle_cycle();
      if (mode >= 2 && $urandom_range(0, 1) == 1) idle_cycle();
      send_byte(load_bytes[i], (mode == 3 && i == 50));
      if (i == 0) first_acc_cyc = last_acc_cyc;
    end
    if (nbytes == NB) begin
      e.vec = model_vec();
      e.acc_cyc = last_acc_cyc;
      sb_q.push_back(e);
      if (mode == 0) check("backtoback_cycles", last_acc_cyc - first_acc_cyc, NB - 1);
      @(negedge clk);
      @(negedge clk);
      check("done_level", cfg_done, 1);
      check("busy_after_done", cfg_busy, 0);
      check("ready_after_done", in_ready, 0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cfg", {sramConfig, cbconfig, sconfig, sel}, '0);
    check("reset_ready", in_ready, 0);
    check("reset_busy", cfg_busy, 0);
    check("reset_done", cfg_done, 0);
    check("reset_error", cfg_error, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Bytes offered in IDLE are refused
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    check("idle_no_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // All ones, back-to-back
    do_load(0, NB);
    check("ones_sram", sramConfig, {SRAM_W{1'b1}});
    check("ones_sel", sel, 9'h1FF);

    // Incrementing bytes with valid toggling
    do_load(1, NB);
    check("inc_sram_top", sramConfig[143:136], 8'h00);
    check("inc_sram_next", sramConfig[135:128], 8'h01);
    check("inc_sel", sel, 9'h08C);

    // Random loads, one of them with an ignored cfg_start mid-load
    do_load(2, NB);
    do_load(3, NB);
    do_load(2, NB);

    // Reset asserted in the middle of a load
    do_load(0, NB);
    do_load(2, 40);
    #2;
    reset = 1'b0;
    #1;
    check("async_cfg", {sramConfig, cbconfig, sconfig, sel}, '0);
    check("async_ready", in_ready, 0);
    check("async_done", cfg_done, 0);
    check("async_busy", cfg_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle_ready", in_ready, 0);
    check("post_reset_idle_busy", cfg_busy, 0);
    @(posedge clk);
    #1;

    // A full load still works after reset
    do_load(2, NB);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
